// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan driver.
// Holds the scan state encoding, blank pattern and one-hot encoder.
package seg7_pkg;

    typedef enum logic [1:0] {
        STATIC,
        BLANK,
        SHOW
    } seg7_state_t;

    localparam logic [7:0] SEG7_BLANK      = 8'h00;
    localparam int         SEG7_NUM_DIGITS = 6;

    function automatic logic [SEG7_NUM_DIGITS-1:0] seg7_onehot(
        input logic [2:0] idx
    );
        logic [SEG7_NUM_DIGITS-1:0] oh;
        oh = '0;
        for (int i = 0; i < SEG7_NUM_DIGITS; i++) begin
            oh[i] = (idx == 3'(i));
        end
        return oh;
    endfunction

endpackage

// File: rtl/seg7_dwell_timer.sv
// Loadable down-counter used for the blank and dwell intervals.
// done_o is high whenever the count has reached zero.
module seg7_dwell_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena_i,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear beats load beats count; the count parks at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (ena_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 6-digit 7-segment scanner with inter-digit blanking.
// Static mode passes the manually selected digit straight through.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int NUM_DIGITS   = SEG7_NUM_DIGITS,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  scan_en,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic [2:0]            manual_sel,
    input  logic [7:0]            seg_in,
    output logic [2:0]            digit_sel,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] dig_en,
    output logic                  frame_pulse
);

    localparam int BLANK_W =
        (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BLANK_W-1:0] BLANK_LD =
        BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

    seg7_state_t           state_q;
    logic [2:0]            digit_sel_q;
    logic [7:0]            seg_out_q;
    logic [NUM_DIGITS-1:0] dig_en_q;
    logic                  frame_pulse_q;

    logic blank_ld, dwell_ld, cnt_clr;
    logic blank_done, dwell_done;
    logic man_ok;
    logic [NUM_DIGITS-1:0] oh_sel, oh_man;

    assign oh_sel = NUM_DIGITS'(seg7_onehot(digit_sel_q));
    assign oh_man = NUM_DIGITS'(seg7_onehot(manual_sel));
    assign man_ok = (manual_sel <= LAST);

    // Timer loads happen on the edge that enters BLANK or SHOW.
    always_comb begin
        blank_ld = 1'b0;
        dwell_ld = 1'b0;
        cnt_clr  = 1'b0;
        if (ena) begin
            unique case (state_q)
                STATIC: blank_ld = scan_en;
                BLANK: begin
                    cnt_clr  = !scan_en;
                    dwell_ld = scan_en && blank_done;
                end
                SHOW: begin
                    cnt_clr  = !scan_en;
                    blank_ld = scan_en && dwell_done;
                end
                default: cnt_clr = 1'b1;
            endcase
        end
    end

    seg7_dwell_timer #(.W(BLANK_W)) u_blank (
        .clk       (clk),
        .rst       (rst),
        .ena_i     (ena && (state_q == BLANK)),
        .clr_i     (cnt_clr),
        .load_i    (blank_ld),
        .load_val_i(BLANK_LD),
        .done_o    (blank_done)
    );

    seg7_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .ena_i     (ena && (state_q == SHOW)),
        .clr_i     (cnt_clr),
        .load_i    (dwell_ld),
        .load_val_i(dwell),
        .done_o    (dwell_done)
    );

    // Scan FSM with registered select, segment and digit outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= STATIC;
            digit_sel_q   <= '0;
            seg_out_q     <= SEG7_BLANK;
            dig_en_q      <= '0;
            frame_pulse_q <= 1'b0;
        end else if (!ena) begin
            frame_pulse_q <= 1'b0;
        end else begin
            frame_pulse_q <= 1'b0;
            if (!scan_en) begin
                state_q     <= STATIC;
                digit_sel_q <= manual_sel;
                seg_out_q   <= man_ok ? seg_in : SEG7_BLANK;
                dig_en_q    <= man_ok ? oh_man : '0;
            end else begin
                unique case (state_q)
                    STATIC: begin
                        state_q     <= BLANK;
                        digit_sel_q <= '0;
                        seg_out_q   <= SEG7_BLANK;
                        dig_en_q    <= '0;
                    end
                    BLANK: begin
                        if (blank_done) begin
                            state_q   <= SHOW;
                            seg_out_q <= seg_in;
                            dig_en_q  <= oh_sel;
                        end
                    end
                    SHOW: begin
                        if (dwell_done) begin
                            state_q       <= BLANK;
                            seg_out_q     <= SEG7_BLANK;
                            dig_en_q      <= '0;
                            frame_pulse_q <= (digit_sel_q == LAST);
                            digit_sel_q   <= (digit_sel_q == LAST) ?
                                             3'd0 : digit_sel_q + 3'd1;
                        end else begin
                            seg_out_q <= seg_in;
                            dig_en_q  <= oh_sel;
                        end
                    end
                    default: state_q <= STATIC;
                endcase
            end
        end
    end

    assign digit_sel   = digit_sel_q;
    assign seg_out     = seg_out_q;
    assign dig_en      = dig_en_q;
    assign frame_pulse = frame_pulse_q;

endmodule
